// File: rtl/motion_xy_if.sv
// Button/position bundle between the input logic, motion_xy_ctrl and the renderer.
// master drives requests and presets; slave is the motion controller.
interface motion_xy_if #(
    parameter int XW = 10,
    parameter int YW = 16
);
    logic          en;
    logic          left;
    logic          right;
    logic          load;
    logic [XW-1:0] load_x;
    logic [XW-1:0] x_ball;
    logic [YW-1:0] y_ball;
    logic          tick;
    logic          moving;
    logic          at_min;
    logic          at_max;

    modport master (
        output en, left, right, load, load_x,
        input  x_ball, y_ball, tick, moving, at_min, at_max
    );

    modport slave (
        input  en, left, right, load, load_x,
        output x_ball, y_ball, tick, moving, at_min, at_max
    );
endinterface

// File: rtl/motion_xy_ctrl.sv
// Tick-paced X/Y position generator: button-driven X with hold-to-accelerate and
// clamp/wrap bounds, plus a free-running modulo Y counter.
module motion_xy_ctrl #(
    parameter int XW          = 10,
    parameter int YW          = 16,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 328,
    parameter int X_INIT      = 164,
    parameter int TICK_DIV    = 250000,
    parameter int DIV_W       = 20,
    parameter int STEP_MAX    = 4,
    parameter int ACCEL_TICKS = 8,
    parameter int WRAP        = 0,
    parameter int Y_STEP      = 1,
    parameter int Y_MAX       = 65535
) (
    input  logic        clk,
    input  logic        reset,
    motion_xy_if.slave  bus
);
    localparam int SW = (STEP_MAX < 2) ? 1 : $clog2(STEP_MAX + 1);
    localparam int HW = (ACCEL_TICKS < 2) ? 1 : $clog2(ACCEL_TICKS);

    localparam logic signed [XW+1:0] XMIN_S = (XW+2)'(X_MIN);
    localparam logic signed [XW+1:0] XMAX_S = (XW+2)'(X_MAX);
    localparam logic signed [XW+1:0] NSPAN  = (XW+2)'(X_MAX - X_MIN + 1);

    typedef enum logic [1:0] {IDLE, MOVE_L, MOVE_R} state_t;

    state_t                 state, state_nx, tgt;
    logic [DIV_W-1:0]       div;
    logic                   tick_r;
    logic                   upd;
    logic [XW-1:0]          x, x_nx;
    logic [YW-1:0]          y;
    logic [SW-1:0]          step, step_nx, step_cur;
    logic [HW-1:0]          hold, hold_nx, hold_cur;
    logic                   moving_r;
    logic                   req_l, req_r, hit;
    logic signed [XW+1:0]   x_s, stp_s, x_mv;

    // Saturate a preset into the legal X range.
    function automatic logic [XW-1:0] clamp_x(input logic [XW-1:0] v);
        logic signed [XW+1:0] vs;
        vs = $signed({2'b00, v});
        if (vs < XMIN_S)      return XW'(X_MIN);
        else if (vs > XMAX_S) return XW'(X_MAX);
        else                  return v;
    endfunction

    function automatic logic [YW-1:0] y_next(input logic [YW-1:0] cur);
        logic [YW:0] sum;
        sum = {1'b0, cur} + (YW+1)'(Y_STEP);
        if ({1'b0, cur} <= (YW+1)'(Y_MAX - Y_STEP)) return YW'(sum);
        else                                        return YW'(sum - (YW+1)'(Y_MAX + 1));
    endfunction

    assign upd   = bus.en & tick_r;
    assign req_l = bus.left & ~bus.right;
    assign req_r = bus.right & ~bus.left;

    // Tick divider: tick is high for the cycle after div reaches TICK_DIV-1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div    <= '0;
            tick_r <= 1'b0;
        end else if (bus.en) begin
            if (div == DIV_W'(TICK_DIV - 1)) begin
                div    <= '0;
                tick_r <= 1'b1;
            end else begin
                div    <= div + DIV_W'(1);
                tick_r <= 1'b0;
            end
        end else begin
            tick_r <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) y <= '0;
        else if (upd) y <= y_next(y);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            x        <= XW'(X_INIT);
            step     <= SW'(1);
            hold     <= '0;
            moving_r <= 1'b0;
        end else begin
            state    <= state_nx;
            x        <= x_nx;
            step     <= step_nx;
            hold     <= hold_nx;
            moving_r <= (state_nx != IDLE);
        end
    end

    always_comb begin
        state_nx = state;
        x_nx     = x;
        step_nx  = step;
        hold_nx  = hold;
        tgt      = state;
        step_cur = step;
        hold_cur = hold;
        hit      = 1'b0;
        x_s      = $signed({2'b00, x});
        stp_s    = '0;
        x_mv     = x_s;
        if (bus.load) begin
            x_nx     = clamp_x(bus.load_x);
            state_nx = IDLE;
            step_nx  = SW'(1);
            hold_nx  = '0;
        end else if (upd) begin
            if (!req_l && !req_r) begin
                state_nx = IDLE;
                step_nx  = SW'(1);
                hold_nx  = '0;
            end else begin
                tgt = req_l ? MOVE_L : MOVE_R;
                // A new or reversed direction restarts acceleration before moving.
                if (state != tgt) begin
                    step_cur = SW'(1);
                    hold_cur = '0;
                end
                stp_s = $signed({{(XW+2-SW){1'b0}}, step_cur});
                if (tgt == MOVE_L) begin
                    x_mv = x_s - stp_s;
                    if (x_mv < XMIN_S) x_mv = (WRAP != 0) ? x_mv + NSPAN : XMIN_S;
                    hit = (WRAP == 0) && (x_mv == XMIN_S);
                end else begin
                    x_mv = x_s + stp_s;
                    if (x_mv > XMAX_S) x_mv = (WRAP != 0) ? x_mv - NSPAN : XMAX_S;
                    hit = (WRAP == 0) && (x_mv == XMAX_S);
                end
                x_nx     = XW'(x_mv);
                state_nx = tgt;
                if (hit) begin
                    step_nx = SW'(1);
                    hold_nx = '0;
                end else if (hold_cur == HW'(ACCEL_TICKS - 1)) begin
                    hold_nx = '0;
                    step_nx = (step_cur == SW'(STEP_MAX)) ? step_cur : step_cur + SW'(1);
                end else begin
                    hold_nx = hold_cur + HW'(1);
                    step_nx = step_cur;
                end
            end
        end
    end

    assign bus.x_ball = x;
    assign bus.y_ball = y;
    assign bus.tick   = tick_r;
    assign bus.moving = moving_r;
    assign bus.at_min = (x == XW'(X_MIN));
    assign bus.at_max = (x == XW'(X_MAX));
endmodule

// File: tb/tb_motion_xy_ctrl.sv
// Directed bench for motion_xy_ctrl: a clamp instance and a wrap instance share stimulus.
// A small divider/Y reference tracks tick timing and Y independently of the DUTs.
module tb_motion_xy_ctrl;
    logic clk;
    logic reset;
    logic en, left, right, load;
    logic [9:0] load_x;

    int n_cmp = 0;
    int n_mis = 0;

    int m_div, m_y;
    logic m_tick;

    motion_xy_if #(.XW(10), .YW(16)) ifc0 ();
    motion_xy_if #(.XW(10), .YW(16)) ifc1 ();

    assign ifc0.en = en;     assign ifc1.en = en;
    assign ifc0.left = left; assign ifc1.left = left;
    assign ifc0.right = right; assign ifc1.right = right;
    assign ifc0.load = load; assign ifc1.load = load;
    assign ifc0.load_x = load_x; assign ifc1.load_x = load_x;

    motion_xy_ctrl #(.TICK_DIV(4), .STEP_MAX(3), .ACCEL_TICKS(2), .Y_MAX(5), .WRAP(0))
        dut_clamp (.clk(clk), .reset(reset), .bus(ifc0));
    motion_xy_ctrl #(.TICK_DIV(4), .STEP_MAX(3), .ACCEL_TICKS(2), .Y_MAX(5), .WRAP(1))
        dut_wrap (.clk(clk), .reset(reset), .bus(ifc1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_div  <= 0;
            m_tick <= 1'b0;
            m_y    <= 0;
        end else if (en) begin
            if (m_tick) m_y <= (m_y == 5) ? 0 : m_y + 1;
            m_tick <= (m_div == 3);
            m_div  <= (m_div == 3) ? 0 : m_div + 1;
        end else begin
            m_tick <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("tick_vs_ref", 32'(ifc0.tick), 32'(m_tick));
            if (ifc0.tick) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_mis++;
            $error("FAIL tick_timeout: observed no tick expected tick within 12 cycles");
        end
        @(negedge clk);
        chk("y_vs_ref", 32'(ifc0.y_ball), 32'(m_y));
    endtask

    task automatic do_load(input logic [9:0] v);
        load_x = v;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    initial begin
        int ys[6];
        int xs[6];
        ys = '{2, 3, 4, 5, 0, 1};
        xs = '{165, 166, 168, 170, 173, 176};
        reset = 1'b0; en = 1'b1; left = 1'b0; right = 1'b0; load = 1'b0; load_x = '0;
        repeat (3) @(negedge clk);
        chk("rst_x", 32'(ifc0.x_ball), 164);
        chk("rst_y", 32'(ifc0.y_ball), 0);
        chk("rst_moving", 32'(ifc0.moving), 0);
        chk("rst_tick", 32'(ifc0.tick), 0);

        reset = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("first_tick", 32'(ifc0.tick), (c == 4) ? 1 : 0);
        end
        @(negedge clk);
        chk("y_seq", 32'(ifc0.y_ball), 1);
        for (int i = 0; i < 6; i++) begin
            wait_tick();
            chk("y_seq", 32'(ifc0.y_ball), 32'(ys[i]));
            chk("idle_x", 32'(ifc0.x_ball), 164);
        end

        right = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_tick();
            chk("accel_x", 32'(ifc0.x_ball), 32'(xs[i]));
            chk("accel_moving", 32'(ifc0.moving), 1);
        end

        do_load(10'd326);
        chk("load_x", 32'(ifc0.x_ball), 326);
        chk("load_moving", 32'(ifc0.moving), 0);
        wait_tick();
        chk("clamp_x1", 32'(ifc0.x_ball), 327);
        wait_tick();
        chk("clamp_x2", 32'(ifc0.x_ball), 328);
        chk("clamp_atmax2", 32'(ifc0.at_max), 1);
        wait_tick();
        chk("clamp_x3", 32'(ifc0.x_ball), 328);
        chk("clamp_atmax3", 32'(ifc0.at_max), 1);
        chk("clamp_moving", 32'(ifc0.moving), 1);
        right = 1'b0;
        wait_tick();
        chk("release_moving", 32'(ifc0.moving), 0);
        chk("release_x", 32'(ifc0.x_ball), 328);

        left = 1'b1;
        do_load(10'd1);
        wait_tick();
        chk("wrap_x1", 32'(ifc1.x_ball), 0);
        chk("wrap_atmin", 32'(ifc1.at_min), 1);
        chk("clampL_x1", 32'(ifc0.x_ball), 0);
        wait_tick();
        chk("wrap_x2", 32'(ifc1.x_ball), 328);
        chk("clampL_x2", 32'(ifc0.x_ball), 0);
        chk("clampL_atmin", 32'(ifc0.at_min), 1);
        wait_tick();
        chk("wrap_x3", 32'(ifc1.x_ball), 326);

        left = 1'b0; right = 1'b1;
        do_load(10'd164);
        wait_tick();
        chk("rev_x1", 32'(ifc0.x_ball), 165);
        wait_tick();
        chk("rev_x2", 32'(ifc0.x_ball), 166);
        wait_tick();
        chk("rev_x3", 32'(ifc0.x_ball), 168);
        right = 1'b0; left = 1'b1;
        wait_tick();
        chk("rev_left", 32'(ifc0.x_ball), 167);
        right = 1'b1;
        wait_tick();
        chk("both_x", 32'(ifc0.x_ball), 167);
        chk("both_moving", 32'(ifc0.moving), 0);

        left = 1'b0; right = 1'b1; en = 1'b0;
        do_load(10'd400);
        chk("load_sat", 32'(ifc0.x_ball), 328);
        chk("load_sat_wrap", 32'(ifc1.x_ball), 328);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("frz_tick", 32'(ifc0.tick), 0);
            chk("frz_x", 32'(ifc0.x_ball), 328);
            chk("frz_y", 32'(ifc0.y_ball), 32'(m_y));
        end
        en = 1'b1;
        wait_tick();
        chk("resume_x", 32'(ifc0.x_ball), 328);
        chk("resume_moving", 32'(ifc0.moving), 1);

        #2 reset = 1'b0;
        #1;
        chk("async_x", 32'(ifc0.x_ball), 164);
        chk("async_y", 32'(ifc0.y_ball), 0);
        chk("async_moving", 32'(ifc0.moving), 0);
        chk("async_wrap_x", 32'(ifc1.x_ball), 164);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no end expected finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
